// File: rtl/program_loader_if.sv
// Stream-in handshake and program-memory write strobes between program_loader and its surroundings.
// master = the loader (sinks the stream, drives the strobes); slave = the stream source / memory side.
interface program_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       mem_write_addr;
   logic       mem_write;

   modport master (
      input  in_data,
      input  in_valid,
      output in_ready,
      output mem_write_addr,
      output mem_write
   );

   modport slave (
      output in_data,
      output in_valid,
      input  in_ready,
      input  mem_write_addr,
      input  mem_write
   );
endinterface

// File: rtl/program_loader.sv
// Framed-stream loader: START, count, data bytes, then an 8-bit sum when PROGRAM_LOADER_CHECKSUM_EN is defined.
// Latency: 3 cycles per data byte (RECV, ADDR, DATA); CHECK adds one cycle and DONE one more.
// Backpressure: in_ready low in ADDR/DATA/DONE; the source holds its byte until it is accepted.
module program_loader #(
   parameter logic [7:0]  START_BYTE = 8'hA5,
   parameter int unsigned MEM_DEPTH  = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   program_loader_if.master pl,
   inout  wire  [7:0]       bus,
   output logic             cpu_hold,
   output logic             done,
   output logic             error
);
   localparam logic [7:0] MAX_COUNT = 8'(MEM_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_COUNT = 3'd1,
      S_RECV  = 3'd2,
      S_ADDR  = 3'd3,
      S_DATA  = 3'd4,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK = 3'd5,
`endif
      S_DONE  = 3'd6,
      S_ERROR = 3'd7
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] remaining_q, remaining_d;
   logic [3:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic       cpu_hold_q, cpu_hold_d;
   logic       error_q, error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;
`endif

   logic       accept;
   logic       drive_en;
   logic [7:0] bus_out;

   assign accept   = pl.in_valid && pl.in_ready;
   assign cpu_hold = cpu_hold_q;
   assign error    = error_q;
   assign bus      = drive_en ? bus_out : 8'hzz;

   // Strobes, in_ready and done are pure decodes of the current state.
   always_comb begin
      pl.in_ready       = 1'b0;
      pl.mem_write_addr = 1'b0;
      pl.mem_write      = 1'b0;
      done              = 1'b0;
      drive_en          = 1'b0;
      bus_out           = data_q;
      case (state_q)
         S_IDLE, S_COUNT, S_RECV, S_ERROR: pl.in_ready = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         S_CHECK: pl.in_ready = 1'b1;
`endif
         S_ADDR: begin
            drive_en          = 1'b1;
            bus_out           = {4'b0000, addr_q};
            pl.mem_write_addr = 1'b1;
         end
         S_DATA: begin
            drive_en     = 1'b1;
            pl.mem_write = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      addr_d      = addr_q;
      data_d      = data_q;
      cpu_hold_d  = cpu_hold_q;
      error_d     = error_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_d       = sum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept && pl.in_data == START_BYTE) begin
               state_d    = S_COUNT;
               cpu_hold_d = 1'b1;
            end
         end
         S_COUNT: begin
            if (accept) begin
               if (pl.in_data != 8'd0 && pl.in_data <= MAX_COUNT) begin
                  state_d     = S_RECV;
                  remaining_d = pl.in_data[4:0];
                  addr_d      = 4'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  sum_d       = 8'd0;
`endif
               end else begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end
            end
         end
         S_RECV: begin
            if (accept) begin
               state_d = S_ADDR;
               data_d  = pl.in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               sum_d   = sum_q + pl.in_data;
`endif
            end
         end
         S_ADDR: state_d = S_DATA;
         S_DATA: begin
            // addr wraps only after the 16th byte, when no further write follows.
            addr_d      = addr_q + 4'd1;
            remaining_d = remaining_q - 5'd1;
            if (remaining_q == 5'd1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_RECV;
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (accept) begin
               if (pl.in_data == sum_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end
            end
         end
`endif
         S_DONE: begin
            state_d    = S_IDLE;
            cpu_hold_d = 1'b0;
            error_d    = 1'b0;
         end
         S_ERROR: begin
            // cpu_hold stays asserted; only a new frame start releases the error.
            if (accept && pl.in_data == START_BYTE) begin
               state_d = S_COUNT;
               error_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         remaining_q <= 5'd0;
         addr_q      <= 4'd0;
         data_q      <= 8'd0;
         cpu_hold_q  <= 1'b0;
         error_q     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         sum_q       <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         cpu_hold_q  <= cpu_hold_d;
         error_q     <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of framed streams with expected memory writes and flags,
// plus hand sequences for reset, frame latency and reset in the middle of a frame.
module tb_program_loader;
   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   wire  [7:0] bus;
   logic       cpu_hold;
   logic       done;
   logic       error;

   program_loader_if pl_if ();

   // Undriven bus reads as FF, so a released bus is distinguishable from a driven value.
   for (genvar gi = 0; gi < 8; gi++) begin : g_pu
      pullup (bus[gi]);
   end

   program_loader dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .pl       (pl_if),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clock = ~clock;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   int cmp_cnt = 0;
   int fail_cnt = 0;
   int cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Memory-side observer: records writes as a memory would see them and counts protocol violations.
   int         wr_cnt = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         viol = 0;
   logic       hold_at_done = 1'b0;
   logic       prev_mwa = 1'b0;
   logic [3:0] lat_addr = 4'd0;
   logic [3:0] wr_addr [128];
   logic [7:0] wr_data [128];
   logic       proto_bad;

   assign proto_bad = (pl_if.mem_write_addr && bus[7:4] != 4'd0)
                   || (pl_if.mem_write && !prev_mwa)
                   || (prev_mwa && !pl_if.mem_write)
                   || (pl_if.mem_write_addr && pl_if.mem_write)
                   || ((pl_if.mem_write_addr || pl_if.mem_write || done) && pl_if.in_ready)
                   || (!pl_if.mem_write_addr && !pl_if.mem_write && bus !== 8'hFF);

   always @(negedge clock) begin
      if (!reset_n) begin
         prev_mwa <= 1'b0;
      end else begin
         prev_mwa <= pl_if.mem_write_addr;
         if (pl_if.mem_write_addr) lat_addr <= bus[3:0];
         if (pl_if.mem_write) begin
            wr_addr[wr_cnt[6:0]] <= lat_addr;
            wr_data[wr_cnt[6:0]] <= bus;
            wr_cnt <= wr_cnt + 1;
         end
         if (done) begin
            done_cnt     <= done_cnt + 1;
            done_cyc     <= cyc;
            hold_at_done <= cpu_hold;
         end
         viol <= viol + (proto_bad ? 1 : 0);
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      pl_if.in_data  = b;
      pl_if.in_valid = 1'b1;
      while (pl_if.in_ready !== 1'b1 && n < 50) begin
         tick(1);
         n++;
      end
      cmp_cnt++;
      if (n >= 50) begin
         fail_cnt++;
         $display("FAIL accept_wait: byte %02h waited %0d cycles, expected under 50", b, n);
      end
      tick(1);
      if (gap > 0) begin
         pl_if.in_valid = 1'b0;
         tick(gap);
      end
   endtask

   task automatic idle(input int n);
      pl_if.in_valid = 1'b0;
      tick(n);
   endtask

   typedef struct packed {
      logic [19:0][7:0] st;
      logic [4:0]       len;
      logic [1:0]       gap;
      logic [4:0]       nwr;
      logic [15:0][7:0] wd;
      logic             ndone;
      logic             err;
      logic             hold;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs [NV];

   int wb, db, vb, t0, n;

   initial begin
      vecs[0] = '{st: {8'h00, 8'h7F, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66, {12{8'h00}}},
                  len: 5'd8, gap: 2'd0, nwr: 5'd3, wd: {8'h11, 8'h22, 8'h33, {13{8'h00}}},
                  ndone: 1'b1, err: 1'b0, hold: 1'b0};
      vecs[1] = '{st: {8'hA5, 8'h10, {16{8'hFF}}, 8'hF0, 8'h00},
                  len: 5'd19, gap: 2'd1, nwr: 5'd16, wd: {16{8'hFF}},
                  ndone: 1'b1, err: 1'b0, hold: 1'b0};
      vecs[2] = '{st: {8'hA5, 8'h11, {18{8'h00}}},
                  len: 5'd2, gap: 2'd0, nwr: 5'd0, wd: {16{8'h00}},
                  ndone: 1'b0, err: 1'b1, hold: 1'b1};
      vecs[3] = '{st: {8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00, {15{8'h00}}},
                  len: 5'd5, gap: 2'd1, nwr: 5'd2, wd: {8'hAA, 8'hBB, {14{8'h00}}},
                  ndone: (CK == 0), err: (CK != 0), hold: (CK != 0)};
      vecs[4] = '{st: {8'hA5, 8'h01, 8'h5C, 8'h5C, {16{8'h00}}},
                  len: 5'd4, gap: 2'd0, nwr: 5'd1, wd: {8'h5C, {15{8'h00}}},
                  ndone: 1'b1, err: 1'b0, hold: 1'b0};
      vecs[5] = '{st: {8'hA5, 8'h00, {18{8'h00}}},
                  len: 5'd2, gap: 2'd0, nwr: 5'd0, wd: {16{8'h00}},
                  ndone: 1'b0, err: 1'b1, hold: 1'b1};
      vecs[6] = '{st: {8'hA5, 8'h01, 8'h07, 8'h07, {16{8'h00}}},
                  len: 5'd4, gap: 2'd2, nwr: 5'd1, wd: {8'h07, {15{8'h00}}},
                  ndone: 1'b1, err: 1'b0, hold: 1'b0};

      pl_if.in_data  = 8'h00;
      pl_if.in_valid = 1'b0;
      reset_n        = 1'b0;
      tick(3);
      check("rst_cpu_hold", cpu_hold, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_bus_released", bus, 8'hFF);
      check("rst_strobes", {pl_if.mem_write_addr, pl_if.mem_write}, 2'b00);
      @(negedge clock);
      reset_n = 1'b1;
      tick(1);
      check("rst_in_ready", pl_if.in_ready, 1'b1);
      tick(2);
      check("rst_no_writes", wr_cnt, 0);

      for (int v = 0; v < NV; v++) begin
         wb = wr_cnt;
         db = done_cnt;
         vb = viol;
         for (int i = 0; i < int'(vecs[v].len); i++) send_byte(vecs[v].st[19 - i], int'(vecs[v].gap));
         idle(12);
         check($sformatf("v%0d_write_count", v), wr_cnt - wb, 32'(vecs[v].nwr));
         for (int i = 0; i < int'(vecs[v].nwr); i++) begin
            check($sformatf("v%0d_addr%0d", v, i), wr_addr[(wb + i) % 128], 32'(i));
            check($sformatf("v%0d_data%0d", v, i), wr_data[(wb + i) % 128], 32'(vecs[v].wd[15 - i]));
         end
         check($sformatf("v%0d_done_pulses", v), done_cnt - db, 32'(vecs[v].ndone));
         check($sformatf("v%0d_error", v), error, vecs[v].err);
         check($sformatf("v%0d_cpu_hold", v), cpu_hold, vecs[v].hold);
         check($sformatf("v%0d_protocol", v), viol - vb, 0);
      end

      // Full-rate frame: cpu_hold timing and START-to-DONE latency.
      wb = wr_cnt;
      db = done_cnt;
      vb = viol;
      check("lat_hold_before", cpu_hold, 1'b0);
      send_byte(8'hA5, 0);
      t0 = cyc;
      check("lat_hold_rise", cpu_hold, 1'b1);
      send_byte(8'h02, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'h46, 0);
      idle(10);
      check("lat_done_pulses", done_cnt - db, 1);
      check("lat_done_cycle", done_cyc - t0, 32'(7 + CK));
      check("lat_hold_in_done", hold_at_done, 1'b1);
      check("lat_hold_fall", cpu_hold, 1'b0);
      check("lat_writes", wr_cnt - wb, 2);
      check("lat_w0", {wr_addr[wb % 128], wr_data[wb % 128]}, 12'h012);
      check("lat_w1", {wr_addr[(wb + 1) % 128], wr_data[(wb + 1) % 128]}, 12'h134);
      check("lat_protocol", viol - vb, 0);

      // Reset in the middle of a frame after two data bytes.
      wb = wr_cnt;
      db = done_cnt;
      send_byte(8'hA5, 0);
      send_byte(8'h04, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      pl_if.in_valid = 1'b0;
      n = 0;
      while (wr_cnt - wb < 2 && n < 20) begin
         tick(1);
         n++;
      end
      check("mid_writes_before", wr_cnt - wb, 2);
      check("mid_hold_before", cpu_hold, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_hold_cleared", cpu_hold, 1'b0);
      check("mid_bus_released", bus, 8'hFF);
      check("mid_strobes", {pl_if.mem_write_addr, pl_if.mem_write, done}, 3'b000);
      @(negedge clock);
      reset_n = 1'b1;
      tick(1);
      check("mid_in_ready", pl_if.in_ready, 1'b1);
      wb = wr_cnt;
      db = done_cnt;
      vb = viol;
      send_byte(8'hA5, 0);
      send_byte(8'h03, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 1);
      send_byte(8'h03, 0);
      send_byte(8'h06, 0);
      idle(12);
      check("post_writes", wr_cnt - wb, 3);
      for (int i = 0; i < 3; i++)
         check($sformatf("post_w%0d", i), {wr_addr[(wb + i) % 128], wr_data[(wb + i) % 128]}, 12'(i * 256 + i + 1));
      check("post_done_pulses", done_cnt - db, 1);
      check("post_error", error, 1'b0);
      check("post_cpu_hold", cpu_hold, 1'b0);
      check("post_protocol", viol - vb, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
